comparator_serial_n_bit: RTL and testbench
==========================================

Name: comparator_serial_n_bit

Overview:
Parametrised, multi-cycle magnitude comparator. It is the successor to the team's 4-bit combinational comparator.
- Compares two DATA_WIDTH operands CHUNK_WIDTH bits per cycle, MSB chunk first, and terminates early on the first differing chunk.
- Supports signed and unsigned modes.
- Uses a start/ready/done handshake, registered results and per-output tristate enable.
- Used where wide compares must not sit in a single combinational path.

Parameters:
DATA_WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK_WIDTH, otherwise elaboration error.
CHUNK_WIDTH, 4, bits compared per cycle; 1 <= CHUNK_WIDTH <= DATA_WIDTH.
NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived (localparam), worst-case compare cycles.

Ports:
Clock_In  input  1  single clock, rising edge.
Reset_n_In  input  1  asynchronous, active-low reset.
Enable_In  input  1  output enable; 0 drives A_gt_B_Out/A_eq_B_Out/A_lt_B_Out to Z.
Start_In  input  1  request; accepted only when Ready_Out=1.
Signed_In  input  1  1 = two's-complement compare, 0 = unsigned; captured with Start_In.
Data_A_In  input  DATA_WIDTH  operand A; captured with Start_In.
Data_B_In  input  DATA_WIDTH  operand B; captured with Start_In.
Ready_Out  output  1  block idle, can accept Start_In.
Done_Out  output  1  one-cycle pulse, result registers just updated.
A_gt_B_Out  output  1  registered A > B (tristated by Enable_In).
A_eq_B_Out  output  1  registered A == B (tristated by Enable_In).
A_lt_B_Out  output  1  registered A < B (tristated by Enable_In).

Behaviour:
Reset values:
- Reset_n_In=0 asynchronously forces state IDLE.
- Ready_Out=1, Done_Out=0.
- gt/eq/lt result registers = 0,0,0.
- Operand shift registers = 0.
- Reset mid-compare discards the operation; no Done_Out is produced.

States:
- IDLE: Ready_Out=1. On a clock edge with Start_In=1, capture operands and go to COMPARE.
  - When Signed_In=1, the MSB of both captured operands is inverted (offset-binary). Signed compare then reduces to unsigned.
  - Chunk counter cleared.
- COMPARE: Ready_Out=0. Each edge compares the top CHUNK_WIDTH bits of A_sh and B_sh.
  - Chunks differ: set gt/lt from the unsigned chunk compare, eq=0, go to DONE.
  - Chunks equal, not last chunk: shift both left by CHUNK_WIDTH, increment counter, stay.
  - Chunks equal, last chunk (counter=NUM_CHUNKS-1): gt=0, eq=1, lt=0, go to DONE.
- DONE: Done_Out=1 for exactly this cycle, Ready_Out=0. Next edge returns to IDLE unconditionally.

Latency and handshake:
- If Start_In is accepted at edge t, Done_Out is high in the cycle following edge t+k.
  - k = 1-based index (from MSB) of the first differing chunk, or NUM_CHUNKS if all chunks are equal.
  - Minimum k is 1; maximum is NUM_CHUNKS.
- Ready_Out returns high after the DONE cycle, so back-to-back throughput is k+2 edges per compare.
- Start_In while Ready_Out=0 is ignored and does not affect the operation in flight.
- Input operand changes after capture have no effect.

Outputs:
- Result registers hold their value from the DONE update until the next DONE update.
- Exactly one of gt/eq/lt is 1 after the first completed compare; before that, all are 0.
- Enable_In only gates the output drivers. It does not affect the FSM, result registers, Ready_Out or Done_Out.

Test Plan:
All scenarios use DATA_WIDTH=16, CHUNK_WIDTH=4, Enable_In=1 unless stated.
1. Reset, then A=0x1234, B=0x1234, Signed=0, Start at edge t -> Done_Out high after edge t+4; eq=1, gt=0, lt=0; Ready_Out high again after edge t+5.
2. A=0x9000, B=0x1000, Signed=0 -> Done after edge t+1 (early exit); gt=1. Then A=0x12A4, B=0x12B4 -> Done after edge t+3; lt=1.
3. A=0x8000, B=0x0001: Signed=1 -> lt=1 with latency 1; same operands with Signed=0 -> gt=1. Also A=0xFFFF, B=0xFFFE, Signed=1 -> gt=1 with latency 4.
4. Start with A=0x0001, B=0x0002, then pulse Start_In with A=0x0003, B=0x0003 while busy -> a single Done_Out with lt=1; the second request is ignored.
5. Enable_In=0 during a compare of A=0x5000, B=0x4000 -> all three result outputs read Z; Done_Out still pulses. Raising Enable_In shows gt=1 without a new Start_In.
6. Assert Reset_n_In=0 asynchronously during COMPARE of 0x1111 vs 0x1111 -> Ready_Out=1, Done_Out=0 and results 000 immediately; no Done_Out follows the reset release.

Source files
------------

// File: rtl/comparator_serial_n_bit.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK_WIDTH bits per cycle, MSB chunk
// first, and stops at the first differing chunk. Signed compares are mapped to offset-binary.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request; Start_In captures operands
// S_COMPARE| comparing the top chunk of the shifted operands each cycle
// S_DONE   | results just updated; Done_Out pulses for this one cycle
module comparator_serial_n_bit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Enable_In,
    input  logic                  Start_In,
    input  logic                  Signed_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Ready_Out,
    output logic                  Done_Out,
    output logic                  A_gt_B_Out,
    output logic                  A_eq_B_Out,
    output logic                  A_lt_B_Out
);

    localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    generate
        if ((CHUNK_WIDTH < 1) || (CHUNK_WIDTH > DATA_WIDTH) ||
            ((DATA_WIDTH % CHUNK_WIDTH) != 0)) begin : g_bad_params
            $error("comparator_serial_n_bit: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    gt_q, gt_d;
    logic                    eq_q, eq_d;
    logic                    lt_q, lt_d;
    logic [CHUNK_WIDTH-1:0]  chunk_a;
    logic [CHUNK_WIDTH-1:0]  chunk_b;
    logic [DATA_WIDTH-1:0]   sign_flip;

    assign chunk_a   = a_sh_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_b   = b_sh_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
    // Flipping both MSBs turns a two's-complement order into a plain unsigned order.
    assign sign_flip = Signed_In ? MSB_MASK : '0;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE: begin
                if (Start_In) begin
                    a_sh_d  = Data_A_In ^ sign_flip;
                    b_sh_d  = Data_B_In ^ sign_flip;
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (chunk_a != chunk_b) begin
                    gt_d    = (chunk_a > chunk_b);
                    eq_d    = 1'b0;
                    lt_d    = (chunk_a < chunk_b);
                    state_d = S_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    a_sh_d = a_sh_q << CHUNK_WIDTH;
                    b_sh_d = b_sh_q << CHUNK_WIDTH;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign Ready_Out  = (state_q == S_IDLE);
    assign Done_Out   = (state_q == S_DONE);
    // Enable only gates the drivers; the result registers keep their value underneath.
    assign A_gt_B_Out = Enable_In ? gt_q : 1'bz;
    assign A_eq_B_Out = Enable_In ? eq_q : 1'bz;
    assign A_lt_B_Out = Enable_In ? lt_q : 1'bz;

endmodule

// File: tb/tb_comparator_serial_n_bit.sv
// Scoreboard bench for comparator_serial_n_bit (16-bit operands, 4-bit chunks): stimulus queues
// expected results and latency, a monitor pops them on every Done_Out pulse.
module tb_comparator_serial_n_bit;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        sgn;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        ready;
    logic        done;
    // Pulled down so a released result bus reads as 0 rather than the register value.
    wire         gt_w;
    wire         eq_w;
    wire         lt_w;
    pulldown (gt_w);
    pulldown (eq_w);
    pulldown (lt_w);

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] res;
        int         start_cyc;
        int         k;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    comparator_serial_n_bit #(
        .DATA_WIDTH (16),
        .CHUNK_WIDTH(4)
    ) dut (
        .Clock_In  (clk),
        .Reset_n_In(rst_n),
        .Enable_In (enable),
        .Start_In  (start),
        .Signed_In (sgn),
        .Data_A_In (data_a),
        .Data_B_In (data_b),
        .Ready_Out (ready),
        .Done_Out  (done),
        .A_gt_B_Out(gt_w),
        .A_eq_B_Out(eq_w),
        .A_lt_B_Out(lt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every Done_Out pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending request at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.nm, "_result"}, {29'd0, gt_w, eq_w, lt_w}, {29'd0, e.res});
                chk({e.nm, "_latency"}, cyc - e.start_cyc, e.k);
            end
        end
    end

    // exp_out is what the gt/eq/lt pins should show at Done (000 when the drivers are released).
    task automatic run_cmp(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [2:0] exp_out, input int k,
                           input logic glitch);
        exp_t e;
        @(negedge clk);
        data_a = a;
        data_b = b;
        sgn    = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.res       = exp_out;
        e.start_cyc = cyc;
        e.k         = k;
        e.nm        = nm;
        sb_q.push_back(e);
        @(negedge clk);
        start = glitch;
        if (glitch) begin
            data_a = 16'h0003;
            data_b = 16'h0003;
            sgn    = 1'b0;
        end
        repeat (k) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk({nm, "_ready_in_done"}, {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk({nm, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        sgn    = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_results", {29'd0, gt_w, eq_w, lt_w}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      name        A         B         sgn   gt/eq/lt k  glitch
        run_cmp("eq_all",   16'h1234, 16'h1234, 1'b0, 3'b010, 4, 1'b0);
        run_cmp("gt_early", 16'h9000, 16'h1000, 1'b0, 3'b100, 1, 1'b0);
        chk("hold_gt", {29'd0, gt_w, eq_w, lt_w}, 32'b100);
        run_cmp("lt_chunk3", 16'h12A4, 16'h12B4, 1'b0, 3'b001, 3, 1'b0);
        run_cmp("s_neg_pos", 16'h8000, 16'h0001, 1'b1, 3'b001, 1, 1'b0);
        run_cmp("u_big_one", 16'h8000, 16'h0001, 1'b0, 3'b100, 1, 1'b0);
        run_cmp("s_m1_m2",   16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4, 1'b0);
        run_cmp("s_m1_p1",   16'hFFFF, 16'h0001, 1'b1, 3'b001, 1, 1'b0);
        run_cmp("busy_start", 16'h0001, 16'h0002, 1'b0, 3'b001, 4, 1'b1);

        @(negedge clk);
        enable = 1'b0;
        run_cmp("tristate", 16'h5000, 16'h4000, 1'b0, 3'b000, 1, 1'b0);
        chk("tristate_idle", {29'd0, gt_w, eq_w, lt_w}, 32'd0);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_reveal", {29'd0, gt_w, eq_w, lt_w}, 32'b100);

        // Reset in the middle of an all-equal compare: nothing is queued, so any Done is an error.
        @(negedge clk);
        data_a = 16'h1111;
        data_b = 16'h1111;
        sgn    = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", {31'd0, ready}, 32'd1);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_results", {29'd0, gt_w, eq_w, lt_w}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("postreset_results", {29'd0, gt_w, eq_w, lt_w}, 32'd0);
        chk("queue_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
